// File: rtl/tx_segment_scheduler_if.sv
// Packet handshake between the segment scheduler (master) and the frame builder / tx memory control (slave).
interface tx_segment_scheduler_if;
  logic [7:0]  txid;
  logic [15:0] segment_num;
  logic        tx_start;
  logic        tx_done;
  logic        maxdetect;

  modport master (
    output txid,
    output segment_num,
    output tx_start,
    input  tx_done,
    input  maxdetect
  );

  modport slave (
    input  txid,
    input  segment_num,
    input  tx_start,
    output tx_done,
    output maxdetect
  );
endinterface

// File: rtl/tx_segment_scheduler.sv
// Sequences one video frame as segments x redundant copies toward the packet builder.
// Optional tx_done watchdog enabled by defining TX_SCHED_TIMEOUT_EN.
module tx_segment_scheduler #(
  parameter int unsigned SEGMENT_NUMBER_MAX = 100,
  parameter int unsigned GAP_CYCLES         = 24
`ifdef TX_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
`endif
) (
  input  logic                          clk125MHz,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          frame_req,
  input  logic [7:0]                    redundancy,
  input  logic [15:0]                   segment_num_max,
  tx_segment_scheduler_if.master        bus,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          timeout_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0] SEG_MAX = 16'(SEGMENT_NUMBER_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t             state;
  logic [7:0]         red_l;
  logic [15:0]        seg_l;
  logic [GAP_W-1:0]   gap_cnt;

  logic [15:0]        seg_clamp_c;
  logic               early_end_c;
  logic               seg_more_c;
  logic               pass_more_c;
  logic               pkt_end_c;

  // State entered after a non-last packet; a zero gap skips straight to START.
  localparam state_t ST_AFTER_PKT = (GAP_CYCLES == 0) ? ST_START : ST_GAP;

`ifdef TX_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
  logic            to_hit_c;
  assign to_hit_c  = (wait_cnt == TO_LAST) && !bus.tx_done;
  assign pkt_end_c = bus.tx_done || to_hit_c;
`else
  assign pkt_end_c   = bus.tx_done;
  assign timeout_err = 1'b0;
`endif

  // Frame-accept sampling and packet-advance decisions.
  always_comb begin
    seg_clamp_c = segment_num_max;
    if (segment_num_max == 16'd0) begin
      seg_clamp_c = 16'd1;
    end else if (segment_num_max > SEG_MAX) begin
      seg_clamp_c = SEG_MAX;
    end
    early_end_c = (bus.txid == 8'd1) && bus.maxdetect;
    seg_more_c  = bus.segment_num < (seg_l - 16'd1);
    pass_more_c = bus.txid < red_l;
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      red_l           <= 8'd1;
      seg_l           <= 16'd1;
      gap_cnt         <= '0;
      bus.txid        <= 8'd1;
      bus.segment_num <= 16'd0;
      bus.tx_start    <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      frame_count     <= 16'd0;
`ifdef TX_SCHED_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      bus.tx_start <= 1'b0;
      frame_done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_req && enable) begin
            red_l <= (redundancy == 8'd0) ? 8'd1 : redundancy;
            seg_l <= seg_clamp_c;
            busy  <= 1'b1;
            state <= ST_START;
          end
        end
        ST_START: begin
          bus.tx_start <= 1'b1;
          state        <= ST_WAIT;
`ifdef TX_SCHED_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
        end
        ST_WAIT: begin
          if (pkt_end_c) begin
            gap_cnt <= '0;
`ifdef TX_SCHED_TIMEOUT_EN
            if (to_hit_c) timeout_err <= 1'b1;
`endif
            if (!early_end_c && seg_more_c) begin
              bus.segment_num <= bus.segment_num + 16'd1;
              state           <= ST_AFTER_PKT;
            end else if (pass_more_c) begin
              // Early end of pass 1 limits later passes to the buffers actually filled.
              if (early_end_c) seg_l <= bus.segment_num + 16'd1;
              bus.segment_num <= 16'd0;
              bus.txid        <= bus.txid + 8'd1;
              state           <= ST_AFTER_PKT;
            end else begin
              state <= ST_DONE;
            end
          end
`ifdef TX_SCHED_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_START;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          frame_done      <= 1'b1;
          frame_count     <= frame_count + 16'd1;
          bus.txid        <= 8'd1;
          bus.segment_num <= 16'd0;
          busy            <= 1'b0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
